// File: rtl/radio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radio_pkg
// Description : Shared constants and state encodings for the radio link
//               transmitter (frame preamble, packet-level and byte-level
//               state machines, default radio handshake timeout).
// Revision    : 1.0 - initial release
// ============================================================================
package radio_pkg;

  // First byte of every frame; deliberately excluded from the checksum.
  localparam logic [7:0] PREAMBLE = 8'hA5;

  // Cycles to wait for the radio to raise busy after a send strobe.
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

  // Preamble, node address and length precede the payload.
  localparam int HDR_BYTES = 3;

  // Packet-level states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } top_state_t;

  // Per-byte radio handshake states.
  typedef enum logic [1:0] {
    B_IDLE    = 2'd0,
    B_ISSUE   = 2'd1,
    B_WAIT_HI = 2'd2,
    B_WAIT_LO = 2'd3
  } byte_state_t;

endpackage
`default_nettype wire

// File: rtl/radio_byte_issuer.sv
`default_nettype none
// ============================================================================
// Module      : radio_byte_issuer
// Description : Hands one byte to the radio using the send/busy handshake.
//               B_ISSUE strobes radio_send for one cycle with the byte on
//               the bus, B_WAIT_HI keeps driving until busy rises (or the
//               timeout expires), B_WAIT_LO releases the bus until busy
//               falls. A new start may be accepted on the cycle busy falls
//               so back-to-back bytes leave no idle cycle.
// Revision    : 1.0 - initial release
//
// Parameters
//   BUSY_TIMEOUT : cycles allowed in B_WAIT_HI before timeout pulses
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : accept byte_in and begin a handshake
//   byte_in      : byte to transmit
//   radio_busy   : radio is shifting a byte
//   radio_send   : one-cycle transmit strobe (never while busy is high)
//   drive_en     : bus output enable (B_ISSUE and B_WAIT_HI only)
//   data_out     : byte to place on the bus when drive_en is high
//   done         : pulse on the cycle the byte completes (busy falls)
//   timeout      : pulse when busy never rose; returns to idle
// ============================================================================
module radio_byte_issuer
  import radio_pkg::*;
#(
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       radio_busy,
  output logic       radio_send,
  output logic       drive_en,
  output logic [7:0] data_out,
  output logic       done,
  output logic       timeout
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  byte_state_t   r_state;
  byte_state_t   w_state_nx;
  logic [7:0]    r_byte;
  logic [TW-1:0] r_timer;
  logic          w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= B_IDLE;
      r_byte  <= 8'h00;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_byte <= byte_in;
      end
      // Timer counts the cycles already spent waiting for busy to rise.
      if (r_state == B_WAIT_HI) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    radio_send = 1'b0;
    drive_en   = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (r_state)
      B_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_state_nx = B_ISSUE;
        end
      end
      B_ISSUE: begin
        drive_en = 1'b1;
        // Hold the strobe back if the radio is still busy.
        if (!radio_busy) begin
          radio_send = 1'b1;
          w_state_nx = B_WAIT_HI;
        end
      end
      B_WAIT_HI: begin
        drive_en = 1'b1;
        if (radio_busy) begin
          w_state_nx = B_WAIT_LO;
        end else if (r_timer == TIMER_LAST) begin
          timeout    = 1'b1;
          w_state_nx = B_IDLE;
        end
      end
      B_WAIT_LO: begin
        if (!radio_busy) begin
          done = 1'b1;
          if (start) begin
            w_load     = 1'b1;
            w_state_nx = B_ISSUE;
          end else begin
            w_state_nx = B_IDLE;
          end
        end
      end
      default: w_state_nx = B_IDLE;
    endcase
  end

  assign data_out = r_byte;

endmodule
`default_nettype wire

// File: rtl/radio_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : radio_link_tx
// Description : Collects sensor bytes into a packet buffer and transmits
//               them to a byte-wide radio as a frame:
//                 A5, NODE_ID, LEN, payload[0..LEN-1] (, CSUM)
//               A packet is sent when the buffer is full or on flush with
//               at least one byte collected. A radio handshake timeout
//               discards the packet and pulses err.
//               Build option: define RADIO_LINK_CSUM_EN to append
//               CSUM = NODE_ID ^ LEN ^ payload bytes.
// Revision    : 1.0 - initial release
//
// Parameters
//   NODE_ID      : node address placed in every frame
//   MAX_LEN      : payload bytes per full packet (1..15)
//   BUSY_TIMEOUT : cycles to wait for radio_busy after a send strobe
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   sample_valid/sample_data/sample_ready : sensor byte handshake
//   flush        : send a partial packet now
//   radio_send   : per-byte transmit strobe
//   radio_receive: always 0
//   radio_busy   : radio is shifting a byte
//   radio_data   : byte bus to the radio, high-Z when not driven
//   pkt_done     : pulse when the last frame byte completes
//   err          : pulse when the radio handshake times out
// ============================================================================
module radio_link_tx
  import radio_pkg::*;
#(
  parameter logic [7:0] NODE_ID      = 8'h01,
  parameter int         MAX_LEN      = 4,
  parameter int         BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       sample_ready,
  input  logic       flush,
  output logic       radio_send,
  output logic       radio_receive,
  input  logic       radio_busy,
  inout  wire  [7:0] radio_data,
  output logic       pkt_done,
  output logic       err
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);
  localparam logic [4:0] HDR_LEN = 5'(HDR_BYTES);
`ifdef RADIO_LINK_CSUM_EN
  localparam logic [4:0] TRAILER_LEN = 5'd1;
`else
  localparam logic [4:0] TRAILER_LEN = 5'd0;
`endif

  top_state_t r_state;
  top_state_t w_state_nx;
  logic [3:0] r_count;
  logic [7:0] r_buffer [MAX_LEN];
  logic [4:0] r_idx;          // frame bytes already handed to the issuer
  logic       w_accept;
  logic       w_have_data;
  logic [4:0] w_frame_len;
  logic [4:0] w_payload_idx;
  logic [7:0] w_byte_sel;
  logic       w_start;
  logic       w_iss_done;
  logic       w_iss_timeout;
  logic       w_drive_en;
  logic [7:0] w_drive_data;
`ifdef RADIO_LINK_CSUM_EN
  logic [7:0] r_payload_xor;
  logic [7:0] w_csum;
`endif

  assign sample_ready  = !rst && (r_state != SEND) && (r_count < MAX_CNT);
  assign w_accept      = sample_valid && sample_ready;
  // A byte accepted alongside flush counts toward the packet.
  assign w_have_data   = (r_count != 4'd0) || w_accept;
  assign w_frame_len   = HDR_LEN + 5'(r_count) + TRAILER_LEN;
  assign w_payload_idx = r_idx - HDR_LEN;
  assign radio_receive = 1'b0;
  assign radio_data    = w_drive_en ? w_drive_data : 8'bz;

`ifdef RADIO_LINK_CSUM_EN
  assign w_csum = NODE_ID ^ {4'b0000, r_count} ^ r_payload_xor;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    pkt_done   = 1'b0;
    err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nx = flush ? SEND : COLLECT;
        end
      end
      COLLECT: begin
        if ((r_count == MAX_CNT) || (flush && w_have_data)) begin
          w_state_nx = SEND;
        end
      end
      SEND: begin
        if (w_iss_timeout) begin
          err        = 1'b1;
          w_state_nx = IDLE;
        end else if (r_idx == 5'd0) begin
          w_start = 1'b1;
        end else if (w_iss_done) begin
          if (r_idx == w_frame_len) begin
            pkt_done   = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_start = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Selects the frame byte at position r_idx.
  always_comb begin
    w_byte_sel = 8'h00;
    if (r_idx == 5'd0) begin
      w_byte_sel = PREAMBLE;
    end else if (r_idx == 5'd1) begin
      w_byte_sel = NODE_ID;
    end else if (r_idx == 5'd2) begin
      w_byte_sel = {4'b0000, r_count};
    end else if (r_idx < HDR_LEN + 5'(r_count)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (w_payload_idx == 5'(i)) begin
          w_byte_sel = r_buffer[i];
        end
      end
    end else begin
`ifdef RADIO_LINK_CSUM_EN
      w_byte_sel = w_csum;
`else
      w_byte_sel = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
      r_idx   <= 5'd0;
    end else begin
      if (pkt_done || err) begin
        r_count <= 4'd0;
      end else if (w_accept) begin
        r_count <= r_count + 4'd1;
      end
      if (r_state != SEND) begin
        r_idx <= 5'd0;
      end else if (w_start) begin
        r_idx <= r_idx + 5'd1;
      end
    end
  end

`ifdef RADIO_LINK_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_payload_xor <= 8'h00;
    end else if (pkt_done || err) begin
      r_payload_xor <= 8'h00;
    end else if (w_accept) begin
      r_payload_xor <= r_payload_xor ^ sample_data;
    end
  end
`endif

  // Payload storage needs no reset: r_count decides what is valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (r_count == 4'(i)) begin
          r_buffer[i] <= sample_data;
        end
      end
    end
  end

  radio_byte_issuer #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) u_issuer (
    .clk        (clk),
    .rst        (rst),
    .start      (w_start),
    .byte_in    (w_byte_sel),
    .radio_busy (radio_busy),
    .radio_send (radio_send),
    .drive_en   (w_drive_en),
    .data_out   (w_drive_data),
    .done       (w_iss_done),
    .timeout    (w_iss_timeout)
  );

endmodule
`default_nettype wire
